serial_add_ctrl: RTL and testbench

Bit-serial add/subtract controller that time-shares a single one-bit full-adder cell over WIDTH clock cycles. It produces a WIDTH-bit sum or difference with carry-out and signed-overflow flags. It sits between a requesting datapath, which issues start with operands, and the combinational full-adder cell, which it sequences one bit per cycle, LSB first. The design trades latency for area against a parallel ripple adder.

---
 rtl/serial_add_pkg.sv | 14 +
 rtl/gfulladd.sv | 16 +
 rtl/serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
//   state_e   : controller state encoding (IDLE / RUN / DONE)
//   MAX_WIDTH : largest supported operand width
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned MAX_WIDTH = 32;

endpackage : serial_add_pkg

// File: rtl/gfulladd.sv
// One-bit combinational full-adder cell.
//   a, b, cin : addend bits and carry-in
//   s         : sum bit
//   cout      : carry-out
module gfulladd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : gfulladd

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. Sequences a single gfulladd cell over WIDTH
// cycles, LSB first, to produce a WIDTH-bit sum or difference with carry-out and
// signed-overflow flags. WIDTH must lie in 1..MAX_WIDTH.
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : request, accepted only when idle
//   sub, cin, a, b : operation select, carry-in, operands (captured with start)
//   busy           : high while bits are being processed
//   done           : one-cycle pulse when sum/cout/ovf are updated
//   sum, cout, ovf : result, carry-out (no-borrow for sub), signed overflow
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned       CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_cout;

    gfulladd u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B and force the carry-in.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    part_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d               = a_q >> 1;
                b_d               = b_q >> 1;
                part_d            = part_q >> 1;
                part_d[WIDTH-1]   = fa_s;
                carry_d           = fa_cout;
                cnt_d             = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = part_d;
                    cout_d  = fa_cout;
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ fa_cout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a WIDTH=8 and a WIDTH=1 instance share
// clock and reset; results are checked against an arithmetic reference model.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start, sub, cin;
    logic [7:0] a, b;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    logic       start1, sub1, cin1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] sum1;

    int n_cmp = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .sub   (sub1),
        .cin   (cin1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1),
        .ovf   (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain w-bit arithmetic; overflow from the true signed result range.
    function automatic void model(input int w, input longint ua, input longint ub,
                                  input bit msub, input bit mcin,
                                  output longint ms, output bit mco, output bit mov);
        longint modv, half, bb, tot, sa, sb, res;
        modv = longint'(1) << w;
        half = modv / 2;
        bb   = msub ? (modv - 1 - ub) : ub;
        tot  = ua + bb + (msub ? 1 : longint'(mcin));
        ms   = tot % modv;
        mco  = (tot >= modv);
        sa   = (ua >= half) ? ua - modv : ua;
        sb   = (ub >= half) ? ub - modv : ub;
        res  = msub ? sa - sb : sa + sb + longint'(mcin);
        mov  = (res >= half) || (res < -half);
    endfunction

    // Issues one operation on the 8-bit instance and follows it to completion.
    // Entered and left at sample time with the instance idle.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input bit tsub,
                        input bit tcin, output logic [7:0] osum, output bit ocout,
                        output bit oovf, output int olat, output bit obusy_ok,
                        output bit opulse_ok);
        a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        olat = 0;
        obusy_ok = 1'b1;
        while (!done && olat < 40) begin
            if (busy !== 1'b1) obusy_ok = 1'b0;
            @(posedge clk); #1;
            olat++;
        end
        if (busy !== 1'b0) obusy_ok = 1'b0;
        osum = sum; ocout = cout; oovf = ovf;
        @(posedge clk); #1;
        opulse_ok = (done === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; sub = 0; cin = 0; a = '0; b = '0;
        start1 = 0; sub1 = 0; cin1 = 0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            n_err++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        n_cmp++;
        if ({busy1, done1, sum1, cout1, ovf1} !== 5'b0) begin
            n_err++;
            $display("FAIL reset1: got busy=%b done=%b sum=%b cout=%b ovf=%b, want all 0",
                     busy1, done1, sum1, cout1, ovf1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0] va[5]  = '{8'h5A, 8'hFF, 8'h00, 8'h0A, 8'h80};
        logic [7:0] vb[5]  = '{8'h3C, 8'h01, 8'h00, 8'h14, 8'h01};
        bit         vs[5]  = '{0, 0, 0, 1, 1};
        bit         vc[5]  = '{0, 0, 1, 0, 0};
        logic [7:0] es[5]  = '{8'h96, 8'h00, 8'h01, 8'hF6, 8'h7F};
        bit         eco[5] = '{0, 1, 0, 0, 1};
        bit         eov[5] = '{1, 0, 0, 0, 1};
        logic [7:0] osum;
        bit         ocout, oovf, bok, pok;
        int         lat;
        for (int i = 0; i < 5; i++) begin
            run8(va[i], vb[i], vs[i], vc[i], osum, ocout, oovf, lat, bok, pok);
            n_cmp++;
            if (lat !== 8) begin
                n_err++;
                $display("FAIL dir%0d_latency: got %0d want 8", i, lat);
            end
            n_cmp++;
            if ({osum, ocout, oovf} !== {es[i], eco[i], eov[i]}) begin
                n_err++;
                $display("FAIL dir%0d_result: got sum=%h cout=%b ovf=%b want %h %b %b",
                         i, osum, ocout, oovf, es[i], eco[i], eov[i]);
            end
            n_cmp++;
            if (!bok || !pok) begin
                n_err++;
                $display("FAIL dir%0d_handshake: busy_ok=%b pulse_ok=%b want 1 1", i, bok, pok);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ta, tb, osum;
        bit         ts, tc, ocout, oovf, bok, pok, mco, mov;
        longint     ms;
        int         lat;
        for (int i = 0; i < 24; i++) begin
            ta = 8'($urandom); tb = 8'($urandom); ts = 1'($urandom); tc = 1'($urandom);
            model(8, longint'(ta), longint'(tb), ts, tc, ms, mco, mov);
            run8(ta, tb, ts, tc, osum, ocout, oovf, lat, bok, pok);
            n_cmp++;
            if ({osum, ocout, oovf} !== {8'(ms), mco, mov} || lat !== 8 || !bok || !pok) begin
                n_err++;
                $display("FAIL rand%0d (%h %s %h c%b): got sum=%h cout=%b ovf=%b lat=%0d, want %h %b %b lat=8",
                         i, ta, ts ? "-" : "+", tb, tc, osum, ocout, oovf, lat, 8'(ms), mco, mov);
            end
        end
    endtask

    // start held high with operands changing every cycle: accepts every 10 edges.
    task automatic test_back_to_back();
        logic [7:0] exp_sum;
        bit         exp_co, exp_ov, mco, mov, want_busy, want_done;
        longint     ms;
        int         ph;
        exp_sum = '0; exp_co = 0; exp_ov = 0;
        for (int k = 0; k < 30; k++) begin
            start = 1'b1;
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
            ph = k % 10;
            if (ph == 0) begin
                model(8, longint'(a), longint'(b), sub, cin, ms, mco, mov);
                exp_sum = 8'(ms); exp_co = mco; exp_ov = mov;
            end
            @(posedge clk); #1;
            want_busy = (ph < 8);
            want_done = (ph == 8);
            n_cmp++;
            if (busy !== want_busy || done !== want_done) begin
                n_err++;
                $display("FAIL b2b_k%0d_flags: got busy=%b done=%b want %b %b",
                         k, busy, done, want_busy, want_done);
            end
            if (want_done) begin
                n_cmp++;
                if ({sum, cout, ovf} !== {exp_sum, exp_co, exp_ov}) begin
                    n_err++;
                    $display("FAIL b2b_k%0d_result: got %h %b %b want %h %b %b",
                             k, sum, cout, ovf, exp_sum, exp_co, exp_ov);
                end
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] osum;
        bit         ocout, oovf, bok, pok, mco, mov;
        longint     ms;
        int         lat, n_done;
        // Leave non-zero results behind so clearing is visible.
        run8(8'h5A, 8'h3C, 1'b0, 1'b0, osum, ocout, oovf, lat, bok, pok);
        a = 8'hFF; b = 8'h01; sub = 0; cin = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            n_err++;
            $display("FAIL midreset_clear: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf);
        end
        rst_n = 1'b1;
        n_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done !== 0) begin
            n_err++;
            $display("FAIL midreset_nodone: got %0d done pulses want 0", n_done);
        end
        model(8, 64'h33, 64'h77, 1'b1, 1'b0, ms, mco, mov);
        run8(8'h33, 8'h77, 1'b1, 1'b0, osum, ocout, oovf, lat, bok, pok);
        n_cmp++;
        if ({osum, ocout, oovf} !== {8'(ms), mco, mov} || lat !== 8 || !bok || !pok) begin
            n_err++;
            $display("FAIL midreset_after: got %h %b %b lat=%0d want %h %b %b lat=8",
                     osum, ocout, oovf, lat, 8'(ms), mco, mov);
        end
    endtask

    task automatic test_width1();
        logic [0:0] ta, tb;
        bit         ts, tc, mco, mov;
        longint     ms;
        logic [0:0] esum;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                ta = 1'b1; tb = 1'b1; ts = 1'b0; tc = 1'b1;
            end else begin
                ta = 1'($urandom); tb = 1'($urandom); ts = 1'($urandom); tc = 1'($urandom);
            end
            model(1, longint'(ta), longint'(tb), ts, tc, ms, mco, mov);
            esum = 1'(ms);
            a1 = ta; b1 = tb; sub1 = ts; cin1 = tc; start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            a1 = ~ta; b1 = ~tb; cin1 = ~tc;
            n_cmp++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                n_err++;
                $display("FAIL w1_%0d_run: got busy=%b done=%b want 1 0", i, busy1, done1);
            end
            @(posedge clk); #1;
            n_cmp++;
            if ({busy1, done1, sum1, cout1, ovf1} !== {1'b0, 1'b1, esum, mco, mov}) begin
                n_err++;
                $display("FAIL w1_%0d_done: got busy=%b done=%b sum=%b cout=%b ovf=%b want 0 1 %b %b %b",
                         i, busy1, done1, sum1, cout1, ovf1, esum, mco, mov);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done1 !== 1'b0) begin
                n_err++;
                $display("FAIL w1_%0d_pulse: got done=%b want 0", i, done1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_add_ctrl
